be_clock_ctrl: RTL and testbench
================================

Name: be_clock_ctrl

Overview:
- Clock sequencer for the 8-bit computer. It generates the computer clock from the board clock iCLK.
- Supports three operating modes: continuous run at a selectable rate, single-step from a push button, and halt (from the halt button or the HLT control-word bit).
- Outputs CLK/NOT_CLK feed the datapath. CLK_EN is a one-iCLK-cycle rising-edge strobe for logic clocked directly from iCLK.

Parameters:
- CLK_FREQ_HZ, 50_000_000, iCLK frequency. Must be >= 256.
- DEBOUNCE_CYCLES, 500_000, iCLK cycles STEP_BTN must be stable before the debounced state changes.
- STEP_HIGH_CYCLES, 5_000_000, iCLK cycles CLK stays high for one manual step.

Ports:
- iCLK  in  1  board clock; every register uses its rising edge.
- iRST_N  in  1  asynchronous reset, active-low.
- CLK_SELECT  in  1  0 = manual step, 1 = continuous. Asynchronous; 2-FF synchronised.
- STEP_BTN  in  1  raw step push button, active-low. 2-FF synchronised, then debounced.
- HLT  in  1  halt push button, active-low. 2-FF synchronised, not debounced.
- HLT_INSTR  in  1  halt bit from the control word, active-high, synchronous to iCLK.
- DIV_CLK  in  3  run rate = 2^DIV_CLK Hz (000 = 1 Hz … 111 = 128 Hz).
- CLK  out  1  computer clock, registered.
- NOT_CLK  out  1  complement of CLK, registered.
- CLK_EN  out  1  one-cycle pulse in the iCLK cycle where CLK goes 0->1.
- HALTED  out  1  high while in S_HALT.

Behaviour:
- Reset (iRST_N=0, asynchronous):
  - Outputs: CLK=0, NOT_CLK=1, CLK_EN=0, HALTED=0.
  - State: FSM=S_IDLE; all counters 0; halt_req=0; debounced step=1.
  - Synchronisers: reset to the inactive level (1 for active-low inputs, 0 for CLK_SELECT).
- Half-period: HP = CLK_FREQ_HZ >> (rate_reg+1) iCLK cycles.
  - rate_reg loads DIV_CLK on entry to S_RUN and at every CLK toggle in S_RUN. A DIV_CLK change mid-half-period never shortens or glitches the current half-period.
- Toggle rule in S_RUN: the counter runs 0..HP-1. At HP-1, CLK toggles and the counter returns to 0.
- CLK_EN:
  - Asserted in the same cycle CLK registers 0->1, in both run and step.
  - Never asserted twice for one CLK high phase.
- Step debounce:
  - The debounced state changes only after the synced STEP_BTN differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - step_evt is a one-cycle pulse on the debounced 1->0 transition.
- Halt request:
  - halt_req is set when synced HLT=0 or HLT_INSTR=1.
  - It is sticky; only iRST_N clears it.
- S_IDLE (manual, CLK=0):
  - halt_req -> S_HALT.
  - Else if CLK_SELECT=1 -> S_RUN, counter=0, first rising toggle after HP cycles.
  - Else if step_evt -> S_STEP (CLK=1, CLK_EN=1, counter=0).
- S_STEP:
  - CLK held high for STEP_HIGH_CYCLES cycles, then CLK=0.
  - Next state: S_HALT if halt_req, else S_IDLE.
  - step_evt, CLK_SELECT changes and a halt arriving mid-step do not truncate the high phase.
- S_RUN:
  - If halt_req or CLK_SELECT=0: with CLK=0, leave immediately; with CLK=1, complete the high half-period, then leave at the falling toggle.
  - Destination: S_HALT if halt_req, else S_IDLE.
  - step_evt is ignored.
  - If halt_req and a rising-toggle point occur in the same cycle, the halt wins: CLK stays 0 and CLK_EN stays 0.
- S_HALT: CLK=0, HALTED=1. All inputs are ignored; exit only via iRST_N.
- Step presses are never queued: a step_evt outside S_IDLE is discarded.
- Reset mid-high-phase: CLK drops asynchronously to 0 with no CLK_EN.

Test Plan:
Bench parameters: CLK_FREQ_HZ=256, DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3.
- Continuous rate: reset, CLK_SELECT=1, DIV_CLK=7 -> CLK toggles every 1 iCLK cycle (period 2). DIV_CLK=0 -> first toggle after 128 cycles, period 256. CLK_EN=1 exactly on each 0->1.
- Manual step and debounce:
  - CLK_SELECT=0; STEP_BTN bounces 0/1 at 2-cycle spacing, then holds 0 for 10 cycles -> exactly one CLK high pulse of 3 cycles and one CLK_EN.
  - A second press during the high phase -> no extra pulse.
- Rate change mid-run: DIV_CLK=6 (HP=2), switched to 7 mid-half-period -> the current half-period still lasts 2 cycles; subsequent half-periods last 1 cycle.
- HLT_INSTR while CLK=1 at DIV_CLK=5 (HP=4) -> the high phase completes its 4 cycles, then CLK=0 and HALTED=1. Later CLK_SELECT toggles and STEP presses -> no CLK activity until iRST_N.
- HLT button pulled low for 1 cycle while CLK=0 in S_IDLE -> S_HALT, HALTED=1 within 3 cycles (synchroniser latency).
- Switching CLK_SELECT 1->0 while CLK=1 -> CLK finishes the high phase, goes 0, FSM in S_IDLE, HALTED=0. A subsequent step then produces one pulse.

Source files
------------

// File: rtl/be_clock_ctrl.sv
// Clock sequencer for the 8-bit computer: derives CLK/NOT_CLK/CLK_EN from the board
// clock in continuous-run, single-step and halt modes.
module be_clock_ctrl #(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
    parameter int unsigned STEP_HIGH_CYCLES = 5_000_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       CLK_SELECT,
    input  logic       STEP_BTN,
    input  logic       HLT,
    input  logic       HLT_INSTR,
    input  logic [2:0] DIV_CLK,
    output logic       CLK,
    output logic       NOT_CLK,
    output logic       CLK_EN,
    output logic       HALTED
);

    localparam logic [31:0] FREQ      = 32'(CLK_FREQ_HZ);
    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] STEP_LAST = 32'(STEP_HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    logic        sel_s1_q, sel_s2_q;
    logic        step_s1_q, step_s2_q;
    logic        hlt_s1_q, hlt_s2_q;
    logic        step_db_q, step_db_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        step_evt_q, step_evt_d;
    logic        halt_req_q, halt_req_d;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [2:0]  rate_q;
    logic        clk_q, nclk_q, clk_en_q, halted_q;

    logic [31:0] hp_last_s;
    logic        run_stop_s;

    // Two-flop synchronisers, resetting to each input's inactive level
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sel_s1_q  <= 1'b0;
            sel_s2_q  <= 1'b0;
            step_s1_q <= 1'b1;
            step_s2_q <= 1'b1;
            hlt_s1_q  <= 1'b1;
            hlt_s2_q  <= 1'b1;
        end else begin
            sel_s1_q  <= CLK_SELECT;
            sel_s2_q  <= sel_s1_q;
            step_s1_q <= STEP_BTN;
            step_s2_q <= step_s1_q;
            hlt_s1_q  <= HLT;
            hlt_s2_q  <= hlt_s1_q;
        end
    end

    // Step debounce next state: flip only after a full run of disagreeing samples
    always_comb begin
        db_cnt_d   = 32'd0;
        step_db_d  = step_db_q;
        step_evt_d = 1'b0;
        if (step_s2_q != step_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                step_db_d  = step_s2_q;
                step_evt_d = step_db_q;
                db_cnt_d   = 32'd0;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end else begin
            db_cnt_d = 32'd0;
        end
    end

    // Halt request is sticky; the FSM acts on the freshly-merged value so a halt
    // coinciding with a rising-toggle point suppresses that rise
    always_comb begin
        halt_req_d = halt_req_q | ~hlt_s2_q | HLT_INSTR;
    end

    // Half-period length for the latched rate, and the condition to leave run mode
    always_comb begin
        hp_last_s  = (FREQ >> ({1'b0, rate_q} + 4'd1)) - 32'd1;
        run_stop_s = halt_req_d | ~sel_s2_q;
    end

    // Debounce and halt-request registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            step_db_q  <= 1'b1;
            db_cnt_q   <= 32'd0;
            step_evt_q <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            step_db_q  <= step_db_d;
            db_cnt_q   <= db_cnt_d;
            step_evt_q <= step_evt_d;
            halt_req_q <= halt_req_d;
        end
    end

    // Sequencer FSM with registered clock, strobe and halt outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= 32'd0;
            rate_q   <= 3'd0;
            clk_q    <= 1'b0;
            nclk_q   <= 1'b1;
            clk_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            clk_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 32'd0;
                    if (halt_req_d) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (sel_s2_q) begin
                        state_q <= S_RUN;
                        rate_q  <= DIV_CLK;
                    end else if (step_evt_q) begin
                        state_q  <= S_STEP;
                        clk_q    <= 1'b1;
                        nclk_q   <= 1'b0;
                        clk_en_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_q    <= 32'd0;
                        clk_q    <= 1'b0;
                        nclk_q   <= 1'b1;
                        state_q  <= halt_req_d ? S_HALT : S_IDLE;
                        halted_q <= halt_req_d;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_RUN: begin
                    // A low phase may be abandoned at once; a high phase always completes
                    if (!clk_q && run_stop_s) begin
                        cnt_q    <= 32'd0;
                        state_q  <= halt_req_d ? S_HALT : S_IDLE;
                        halted_q <= halt_req_d;
                    end else if (cnt_q == hp_last_s) begin
                        cnt_q    <= 32'd0;
                        clk_q    <= ~clk_q;
                        nclk_q   <= clk_q;
                        clk_en_q <= ~clk_q;
                        rate_q   <= DIV_CLK;
                        if (clk_q && run_stop_s) begin
                            state_q  <= halt_req_d ? S_HALT : S_IDLE;
                            halted_q <= halt_req_d;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_HALT: begin
                    state_q  <= S_HALT;
                    clk_q    <= 1'b0;
                    nclk_q   <= 1'b1;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= 32'd0;
                    clk_q    <= 1'b0;
                    nclk_q   <= 1'b1;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign CLK     = clk_q;
    assign NOT_CLK = nclk_q;
    assign CLK_EN  = clk_en_q;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_be_clock_ctrl.sv
// Self-checking bench for be_clock_ctrl: randomized run rates and step-button
// patterns compared against an arithmetic / run-length reference model.
module tb_be_clock_ctrl;

    localparam int FREQ  = 256;
    localparam int DEB   = 4;
    localparam int STEPH = 3;
    localparam int LIMIT = 1000;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       CLK_SELECT = 1'b0;
    logic       STEP_BTN = 1'b1;
    logic       HLT = 1'b1;
    logic       HLT_INSTR = 1'b0;
    logic [2:0] DIV_CLK = 3'd7;
    logic       CLK, NOT_CLK, CLK_EN, HALTED;

    int checks = 0;
    int errors = 0;
    int rises = 0, ens = 0, en_bad = 0, nclk_bad = 0, high_cyc = 0;
    logic prev_clk = 1'b0;
    bit btn_hist[$];

    be_clock_ctrl #(
        .CLK_FREQ_HZ(FREQ), .DEBOUNCE_CYCLES(DEB), .STEP_HIGH_CYCLES(STEPH)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .CLK_SELECT(CLK_SELECT), .STEP_BTN(STEP_BTN),
        .HLT(HLT), .HLT_INSTR(HLT_INSTR), .DIV_CLK(DIV_CLK),
        .CLK(CLK), .NOT_CLK(NOT_CLK), .CLK_EN(CLK_EN), .HALTED(HALTED)
    );

    always #5 iCLK = ~iCLK;

    // Observe rising edges, strobes and high time on the inactive edge
    always @(negedge iCLK) begin
        if (CLK === 1'b1 && prev_clk === 1'b0) rises <= rises + 1;
        if (CLK === 1'b1) high_cyc <= high_cyc + 1;
        if (CLK_EN === 1'b1) ens <= ens + 1;
        if (CLK_EN !== (CLK === 1'b1 && prev_clk === 1'b0)) en_bad <= en_bad + 1;
        if (NOT_CLK !== ~CLK) nclk_bad <= nclk_bad + 1;
        prev_clk <= CLK;
    end

    function automatic int hp_model(input int div);
        return FREQ >> (div + 1);
    endfunction

    // Count debounced presses: a level is accepted after DEB consecutive differing samples
    function automatic int press_model(input bit hist[$]);
        bit db = 1'b1;
        int run = 0;
        int presses = 0;
        foreach (hist[i]) begin
            if (hist[i] != db) begin
                run++;
                if (run == DEB) begin
                    db = hist[i];
                    run = 0;
                    if (!db) presses++;
                end
            end else begin
                run = 0;
            end
        end
        return presses;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_btn(input bit v, input int n);
        STEP_BTN = v;
        repeat (n) begin
            btn_hist.push_back(v);
            tick();
        end
    endtask

    task automatic measure(output int len);
        logic lvl;
        lvl = CLK;
        len = 0;
        while (CLK === lvl && len < LIMIT) begin
            tick();
            len++;
        end
    endtask

    task automatic wait_high(output int n);
        n = 0;
        while (CLK !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        CLK_SELECT = 1'b0;
        STEP_BTN = 1'b1;
        HLT = 1'b1;
        HLT_INSTR = 1'b0;
        DIV_CLK = 3'd7;
        ticks(3);
        iRST_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int r0;
        do_reset();
        checks++; if (CLK !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", CLK); end
        checks++; if (NOT_CLK !== 1'b1) begin errors++; $display("FAIL reset_notclk: got %b expected 1", NOT_CLK); end
        checks++; if (CLK_EN !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b expected 0", CLK_EN); end
        checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
        r0 = rises;
        ticks(10);
        checks++; if (rises !== r0) begin errors++; $display("FAIL idle_quiet: got %0d rises expected 0", rises - r0); end
    endtask

    task automatic test_run_rate();
        int n, len, r0, e0;
        do_reset();
        r0 = rises; e0 = ens;
        DIV_CLK = 3'd7;
        CLK_SELECT = 1'b1;
        wait_high(n);
        checks++; if (n !== hp_model(7) + 3) begin errors++; $display("FAIL first_rise_div7: got %0d expected %0d", n, hp_model(7) + 3); end
        for (int i = 0; i < 6; i++) begin
            measure(len);
            checks++; if (len !== hp_model(7)) begin errors++; $display("FAIL phase_div7[%0d]: got %0d expected %0d", i, len, hp_model(7)); end
        end
        do_reset();
        DIV_CLK = 3'd0;
        CLK_SELECT = 1'b1;
        wait_high(n);
        checks++; if (n !== hp_model(0) + 3) begin errors++; $display("FAIL first_rise_div0: got %0d expected %0d", n, hp_model(0) + 3); end
        measure(len);
        checks++; if (len !== hp_model(0)) begin errors++; $display("FAIL high_div0: got %0d expected %0d", len, hp_model(0)); end
        measure(len);
        checks++; if (len !== hp_model(0)) begin errors++; $display("FAIL low_div0: got %0d expected %0d", len, hp_model(0)); end
        checks++; if ((ens - e0) !== (rises - r0)) begin errors++; $display("FAIL run_clken_count: got %0d expected %0d", ens - e0, rises - r0); end
    endtask

    task automatic test_step_debounce();
        int r0, h0, e0, exp;
        do_reset();
        btn_hist.delete();
        r0 = rises; h0 = high_cyc; e0 = ens;
        for (int i = 0; i < 4; i++) begin
            drive_btn(1'b0, 2);
            drive_btn(1'b1, 2);
        end
        drive_btn(1'b0, 6);
        drive_btn(1'b1, 1);
        drive_btn(1'b0, 3);
        drive_btn(1'b1, 20);
        exp = press_model(btn_hist);
        checks++; if ((rises - r0) !== exp || exp !== 1) begin errors++; $display("FAIL step_pulses: got %0d expected %0d", rises - r0, exp); end
        checks++; if ((high_cyc - h0) !== STEPH * exp) begin errors++; $display("FAIL step_high: got %0d expected %0d", high_cyc - h0, STEPH * exp); end
        checks++; if ((ens - e0) !== exp) begin errors++; $display("FAIL step_clken: got %0d expected %0d", ens - e0, exp); end
    endtask

    task automatic test_step_random();
        int r0, h0, exp;
        do_reset();
        btn_hist.delete();
        r0 = rises; h0 = high_cyc;
        for (int i = 0; i < 8; i++) begin
            drive_btn(1'b0, int'($urandom_range(1, 9)));
            drive_btn(1'b1, int'($urandom_range(1, 9)));
        end
        drive_btn(1'b1, 12);
        exp = press_model(btn_hist);
        checks++; if ((rises - r0) !== exp) begin errors++; $display("FAIL rand_step_pulses: got %0d expected %0d", rises - r0, exp); end
        checks++; if ((high_cyc - h0) !== STEPH * exp) begin errors++; $display("FAIL rand_step_high: got %0d expected %0d", high_cyc - h0, STEPH * exp); end
    endtask

    task automatic test_rate_change();
        int n, len;
        do_reset();
        DIV_CLK = 3'd6;
        CLK_SELECT = 1'b1;
        wait_high(n);
        checks++; if (n >= LIMIT) begin errors++; $display("FAIL rate_chg_start: got timeout expected rise"); end
        tick();
        DIV_CLK = 3'd7;
        measure(len);
        checks++; if (len + 1 !== hp_model(6)) begin errors++; $display("FAIL rate_chg_current: got %0d expected %0d", len + 1, hp_model(6)); end
        for (int i = 0; i < 3; i++) begin
            measure(len);
            checks++; if (len !== hp_model(7)) begin errors++; $display("FAIL rate_chg_next[%0d]: got %0d expected %0d", i, len, hp_model(7)); end
        end
    endtask

    task automatic test_hlt_instr();
        int n, len, r0;
        do_reset();
        DIV_CLK = 3'd5;
        CLK_SELECT = 1'b1;
        wait_high(n);
        tick();
        HLT_INSTR = 1'b1;
        tick();
        HLT_INSTR = 1'b0;
        measure(len);
        checks++; if (len + 2 !== hp_model(5)) begin errors++; $display("FAIL hlt_instr_high: got %0d expected %0d", len + 2, hp_model(5)); end
        checks++; if (HALTED !== 1'b1 || CLK !== 1'b0) begin errors++; $display("FAIL hlt_instr_halted: got %b/%b expected 1/0", HALTED, CLK); end
        r0 = rises;
        CLK_SELECT = 1'b0; ticks(5);
        CLK_SELECT = 1'b1; ticks(5);
        CLK_SELECT = 1'b0;
        drive_btn(1'b0, 8);
        drive_btn(1'b1, 10);
        checks++; if (rises !== r0 || HALTED !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0d rises halted=%b expected 0 rises halted=1", rises - r0, HALTED); end
        do_reset();
        checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b expected 0", HALTED); end
    endtask

    task automatic test_hlt_button();
        do_reset();
        HLT = 1'b0;
        tick();
        HLT = 1'b1;
        ticks(2);
        checks++; if (HALTED !== 1'b1 || CLK !== 1'b0) begin errors++; $display("FAIL hlt_button: got halted=%b clk=%b expected 1/0", HALTED, CLK); end
    endtask

    task automatic test_sel_switch();
        int n, len, r0, h0;
        do_reset();
        DIV_CLK = 3'd5;
        CLK_SELECT = 1'b1;
        wait_high(n);
        tick();
        CLK_SELECT = 1'b0;
        measure(len);
        checks++; if (len + 1 !== hp_model(5)) begin errors++; $display("FAIL sel_off_high: got %0d expected %0d", len + 1, hp_model(5)); end
        r0 = rises; h0 = high_cyc;
        ticks(10);
        checks++; if (rises !== r0 || HALTED !== 1'b0) begin errors++; $display("FAIL sel_off_idle: got %0d rises halted=%b expected 0/0", rises - r0, HALTED); end
        drive_btn(1'b0, 8);
        drive_btn(1'b1, 12);
        checks++; if ((rises - r0) !== 1 || (high_cyc - h0) !== STEPH) begin errors++; $display("FAIL sel_off_step: got %0d rises %0d high expected 1/%0d", rises - r0, high_cyc - h0, STEPH); end
    endtask

    task automatic test_reset_mid_high();
        int n;
        do_reset();
        DIV_CLK = 3'd4;
        CLK_SELECT = 1'b1;
        wait_high(n);
        tick();
        #2;
        iRST_N = 1'b0;
        #1;
        checks++; if (CLK !== 1'b0 || NOT_CLK !== 1'b1 || CLK_EN !== 1'b0) begin errors++; $display("FAIL async_reset: got clk=%b nclk=%b en=%b expected 0/1/0", CLK, NOT_CLK, CLK_EN); end
        ticks(2);
        iRST_N = 1'b1;
        tick();
    endtask

    task automatic test_random_run();
        int len, div;
        do_reset();
        CLK_SELECT = 1'b1;
        for (int i = 0; i < 8; i++) begin
            div = int'($urandom_range(3, 7));
            DIV_CLK = 3'(div);
            ticks(int'($urandom_range(0, 5)));
            measure(len);
            for (int k = 0; k < 2; k++) begin
                measure(len);
                checks++; if (len !== hp_model(div)) begin errors++; $display("FAIL rand_run[%0d.%0d] div=%0d: got %0d expected %0d", i, k, div, len, hp_model(div)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_rate();
        test_step_debounce();
        test_step_random();
        test_rate_change();
        test_hlt_instr();
        test_hlt_button();
        test_sel_switch();
        test_reset_mid_high();
        test_random_run();
        checks++; if (en_bad !== 0) begin errors++; $display("FAIL clken_alignment: got %0d bad cycles expected 0", en_bad); end
        checks++; if (nclk_bad !== 0) begin errors++; $display("FAIL notclk_complement: got %0d bad cycles expected 0", nclk_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
